// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce_sync block.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_CNT_W           = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/debounce_sync_chain.sv
// sync_chain: shift-register synchroniser for one asynchronous bit.
// Every stage clears to 0 on synchronous reset. The output is the last stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw bit one stage deeper every clock; reset flushes the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchroniser plus counter-based debounce FSM for one
// bouncing switch/button input. Produces a clean registered level q.
// Build option: define DEBOUNCE_SYNC_PULSE_EN to get registered one-cycle
// rise/fall pulses; without it both pulses are tied to 0 and no pulse
// flops exist. The q behaviour is identical in both builds.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic q,
  output logic rise,
  output logic fall
);

  // The FSM state/level registers act as the final resolving stage of the
  // synchroniser, so the dedicated chain is one flop shorter. This makes q
  // move on edge SYNC_STAGES+DEBOUNCE_CYCLES-1 counted from the edge that
  // first samples a new din_raw level.
  localparam int CHAIN_STAGES = (SYNC_STAGES > 1) ? SYNC_STAGES - 1 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

  if (DEBOUNCE_CYCLES >= (2 ** CNT_W) || DEBOUNCE_CYCLES < 1) begin : g_cntCheck
    $error("debounce_sync: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_syncCheck
    $error("debounce_sync: SYNC_STAGES must be in 2 .. 4");
  end

  logic             syncLevel;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             accept;

  sync_chain #(
    .STAGES (CHAIN_STAGES)
  ) u_syncChain (
    .clk (clk),
    .rst (rst),
    .d   (din_raw),
    .q   (syncLevel)
  );

  // State, counter and debounced level registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Next-state logic: count consecutive disagreements between the
  // synchronised input and q, flip q once the run reaches DEBOUNCE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    case (state_q)
      IDLE_LOW, IDLE_HIGH: begin
        if (syncLevel != level_q) begin
          if (SINGLE_CYCLE) begin
            accept = 1'b1;
          end else begin
            state_d = level_q ? WAIT_LOW : WAIT_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH, WAIT_LOW: begin
        if (syncLevel == level_q) begin
          state_d = level_q ? IDLE_HIGH : IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      level_d = ~level_q;
      cnt_d   = '0;
      state_d = level_q ? IDLE_LOW : IDLE_HIGH;
    end
  end

  assign q = level_q;

`ifdef DEBOUNCE_SYNC_PULSE_EN
  logic rise_q, fall_q;

  // Pulses are registered alongside q so they line up with the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & ~level_q;
      fall_q <= accept & level_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Testbench for debounce_sync (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// The reference model keeps a history of the level the debouncer can see
// each edge and flips its q when the last DEBOUNCE_CYCLES visible samples
// all disagree with it. Expected outputs are queued per edge and checked
// by an independent monitor.
module tb_debounce_sync;
  import debounce_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 4;
  localparam int LAG  = SYNC - 1;

`ifdef DEBOUNCE_SYNC_PULSE_EN
  localparam bit PULSES = 1'b1;
`else
  localparam bit PULSES = 1'b0;
`endif

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dinRaw = 1'b0;
  logic q, rise, fall;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   stimDone = 1'b0;

  logic modelQ = 1'b0;
  logic sampHist[$];
  logic visHist[$];

  debounce_sync #(
    .SYNC_STAGES     (SYNC),
    .CNT_W           (CW),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din_raw (dinRaw),
    .q       (q),
    .rise    (rise),
    .fall    (fall)
  );

  always #5 clk = ~clk;

  // Reference: what should be visible after the coming posedge given rst/din.
  task automatic modelStep(input logic r, input logic d);
    exp_t e;
    logic vis;
    bit   allDiff;
    e = '0;
    if (r) begin
      modelQ = 1'b0;
      sampHist.delete();
      visHist.delete();
    end else begin
      vis = (sampHist.size() >= LAG) ? sampHist[sampHist.size() - LAG] : 1'b0;
      sampHist.push_back(d);
      visHist.push_back(vis);
      if (sampHist.size() > 16) void'(sampHist.pop_front());
      if (visHist.size() > 16) void'(visHist.pop_front());
      allDiff = (visHist.size() >= DEB);
      if (allDiff) begin
        for (int i = visHist.size() - DEB; i < visHist.size(); i++) begin
          if (visHist[i] == modelQ) allDiff = 1'b0;
        end
      end
      if (allDiff) begin
        modelQ = ~modelQ;
        e.rise = PULSES & modelQ;
        e.fall = PULSES & ~modelQ;
      end
    end
    e.q = modelQ;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst    = r;
      dinRaw = d;
      modelStep(r, d);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (q !== e.q) begin
      errors++;
      $display("[TB] FAIL q at %0t: got %b expected %b", $time, q, e.q);
    end
    checks++;
    if (rise !== e.rise) begin
      errors++;
      $display("[TB] FAIL rise at %0t: got %b expected %b", $time, rise, e.rise);
    end
    checks++;
    if (fall !== e.fall) begin
      errors++;
      $display("[TB] FAIL fall at %0t: got %b expected %b", $time, fall, e.fall);
    end
    checks++;
    if (rise === 1'b1 && fall === 1'b1) begin
      errors++;
      $display("[TB] FAIL pulseExclusive at %0t: rise=%b fall=%b expected not both 1",
               $time, rise, fall);
    end
  endtask

  // Monitor: after every posedge compare the DUT against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed scenarios first, then randomised segments with occasional reset.
  initial begin
    $display("[TB] debounce_sync bench start, pulses=%0d", PULSES);
    // reset held with din=1, then release: q rises on 5th post-release edge
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 8);
    // clean 1->0 then 0->1 steps
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 10);
    // glitch shorter than the debounce window
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 10);
    // bounce then steady high, then steady low
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 10);
    // reset in the middle of a count
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 8);
    // fast toggling never settles
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'(i % 2), 2);
    // random segments
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end else begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 8));
      end
    end
    applyStimulus(1'b0, 1'b1, 10);
    stimDone = 1'b1;
  end

  // End of run: drain the scoreboard within a bounded number of cycles.
  initial begin
    int waitCycles;
    waitCycles = 0;
    while (!stimDone && waitCycles < 20000) begin
      @(negedge clk);
      waitCycles++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!stimDone || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: stimDone=%0d pending=%0d expected stimDone=1 pending=0",
               stimDone, expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
